// File: rtl/popcount_dot_pkg.sv
// Shared types, widths and helpers for the binary dot-product sequencer.
package popcount_dot_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned POP_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_AND  = 1'b0,
    OP_XNOR = 1'b1
  } op_t;

  // Mask keeping the low 'tail' bits of a word; tail == 0 keeps the full word.
  function automatic logic [WORD_W-1:0] tail_mask(input logic [5:0] tail);
    logic [WORD_W-1:0] mask;
    if (tail == 6'd0) begin
      mask = '1;
    end else begin
      mask = (64'd1 << tail) - 64'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/popcount64.sv
// Combinational population count of one 64-bit word.
module popcount64
  import popcount_dot_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  output logic [POP_W-1:0]  count_o
);

  // Sum of set bits; synthesis folds this into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count_o = count_o + POP_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_dot_seq.sv
// Binary dot-product sequencer: streams operand word pairs through a
// combine/mask stage, a registered popcount stage and an accumulator, then
// presents the popcount sum and the +-1 dot product on a valid/ready port.
module popcount_dot_seq
  import popcount_dot_pkg::*;
#(
  parameter int unsigned LEN_W = 12,
  parameter int unsigned ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [5:0]              cfg_tail,
  input  logic                    cfg_op,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_a,
  input  logic [WORD_W-1:0]       in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_pop,
  output logic signed [ACC_W:0]   out_dot,
  output logic                    busy
);

  // The accumulator must hold 64 * (2^LEN_W - 1) plus headroom for the dot.
  if (ACC_W < LEN_W + 7) begin : g_acc_w_check
    $error("popcount_dot_seq: ACC_W must be >= LEN_W + 7");
  end

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [5:0]        tail_q, tail_d;
  op_t               op_q, op_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  nbits_q, nbits_d;
  logic [WORD_W-1:0] s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;

  logic [POP_W-1:0]  pop;
  logic [WORD_W-1:0] word_comb;
  logic              last_word;
  logic [ACC_W:0]    dot_val;

  popcount64 u_popcount (
    .data_i  (s1_q),
    .count_o (pop)
  );

  assign word_comb = (op_q == OP_XNOR) ? ~(in_a ^ in_b) : (in_a & in_b);
  assign last_word = (rem_q == LEN_W'(1));
  // 2*pop - nbits; 2*acc cannot reach bit ACC_W given the width check above.
  assign dot_val   = {acc_q, 1'b0} - {1'b0, nbits_q};

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tail_d     = tail_q;
    op_d       = op_q;
    nbits_d    = nbits_q;
    s1_d       = s1_q;
    s1_valid_d = 1'b0;
    // Stage-1 popcount lands in the accumulator one cycle after capture.
    acc_d      = s1_valid_q ? (acc_q + ACC_W'(pop)) : acc_q;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          rem_d   = cfg_len;
          tail_d  = cfg_tail;
          op_d    = op_t'(cfg_op);
          acc_d   = '0;
          nbits_d = '0;
          state_d = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s1_d       = last_word ? (word_comb & tail_mask(tail_q)) : word_comb;
          s1_valid_d = 1'b1;
          nbits_d    = nbits_q + ((last_word && tail_q != 6'd0) ? ACC_W'(tail_q)
                                                                : ACC_W'(WORD_W));
          rem_d      = rem_q - LEN_W'(1);
          if (last_word) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result outputs are forced to zero outside DONE so no partial sum leaks.
  always_comb begin
    out_pop = '0;
    out_dot = '0;
    busy    = (state_q != IDLE);
    if (state_q == DONE) begin
      out_pop = acc_q;
      out_dot = $signed(dot_val);
    end
  end

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      tail_q     <= '0;
      op_q       <= OP_AND;
      acc_q      <= '0;
      nbits_q    <= '0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tail_q     <= tail_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      nbits_q    <= nbits_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
    end
  end

endmodule

// File: tb/tb_popcount_dot_seq.sv
// Directed and randomized bench for popcount_dot_seq with a bit-level
// reference model of the dot-product job.
module tb_popcount_dot_seq;

  localparam int unsigned LEN_W = 12;
  localparam int unsigned ACC_W = 19;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [LEN_W-1:0]      cfg_len;
  logic [5:0]            cfg_tail;
  logic                  cfg_op;
  logic                  in_valid;
  logic                  in_ready;
  logic [63:0]           in_a;
  logic [63:0]           in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_pop;
  logic signed [ACC_W:0] out_dot;
  logic                  busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];

  popcount_dot_seq #(
    .LEN_W (LEN_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_len   (cfg_len),
    .cfg_tail  (cfg_tail),
    .cfg_op    (cfg_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pop   (out_pop),
    .out_dot   (out_dot),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-level reference: count matching bits over every valid bit of the job.
  task automatic model(input int len, input int tail, input logic op,
                       output longint pop, output longint dot);
    longint nb;
    logic [63:0] w;
    int bits;
    pop = 0;
    nb  = 0;
    for (int i = 0; i < len; i++) begin
      w    = op ? ~(qa[i] ^ qb[i]) : (qa[i] & qb[i]);
      bits = (i == len - 1 && tail != 0) ? tail : 64;
      for (int j = 0; j < bits; j++) pop += longint'(w[j]);
      nb += bits;
    end
    dot = 2 * pop - nb;
  endtask

  task automatic start_job(input int len, input int tail, input logic op);
    int n;
    cfg_len   = LEN_W'(len);
    cfg_tail  = 6'(tail);
    cfg_op    = op;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic send_word(input logic [63:0] a, input logic [63:0] b);
    int n;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    qa.push_back(a);
    qb.push_back(b);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input longint pop, input longint dot);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_pop"}, out_pop, pop);
    chk({tag, "_dot"}, out_dot, dot);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    longint ep, ed;
    int len, tail;
    logic op;
    logic pattern [7];
    int idx;

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    cfg_tail  = '0;
    cfg_op    = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pop", out_pop, 0);
    chk("rst_out_dot", out_dot, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single full word, AND of all-ones; latency of two edges to out_valid.
    start_job(1, 0, 1'b0);
    send_word('1, '1);
    chk("t1_drain_no_valid", out_valid, 0);
    chk("t1_drain_in_ready", in_ready, 0);
    tick();
    chk("t1_valid_latency", out_valid, 1);
    take_result("t1", 64, 64);

    // XNOR of zeros with a 10-bit tail on the third word only.
    start_job(3, 10, 1'b1);
    for (int i = 0; i < 3; i++) send_word('0, '0);
    take_result("t2", 138, 138);

    // XNOR of opposite words: no matches, dot = -128.
    start_job(2, 0, 1'b1);
    for (int i = 0; i < 2; i++) send_word('0, '1);
    take_result("t3", 0, -128);

    // Zero-length job; result held under backpressure, stray cfg ignored.
    start_job(0, 0, 1'b0);
    chk("t4_valid_1cyc", out_valid, 1);
    cfg_len   = LEN_W'(5);
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_pop", out_pop, 0);
      chk("t4_hold_cfg_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    take_result("t4", 0, 0);
    tick();
    chk("t4_not_queued", busy, 0);

    // Four random words with a fixed in_valid gap pattern.
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tail = $urandom_range(0, 63);
    op   = 1'($urandom_range(0, 1));
    start_job(4, tail, op);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pattern[i];
      if (pattern[i]) begin
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        qa.push_back(in_a);
        qb.push_back(in_b);
        idx++;
      end
      tick();
      chk("t5_busy", busy, 1);
    end
    in_valid = 1'b0;
    model(4, tail, op, ep, ed);
    take_result("t5", ep, ed);

    // Randomized jobs with random gaps, lengths, tails and ops.
    for (int j = 0; j < 8; j++) begin
      len  = $urandom_range(0, 6);
      tail = $urandom_range(0, 63);
      op   = 1'($urandom_range(0, 1));
      start_job(len, tail, op);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0) tick();
        send_word({$urandom, $urandom}, {$urandom, $urandom});
      end
      model(len, tail, op, ep, ed);
      take_result("rnd", ep, ed);
    end

    // Asynchronous reset in the middle of a job.
    start_job(4, 0, 1'b0);
    send_word('1, '1);
    send_word('1, '1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_pop", out_pop, 0);
    chk("mid_rst_out_dot", out_dot, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(1, 0, 1'b0);
    send_word(64'h3, 64'h1);
    take_result("post_rst", 1, -62);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
